// File: rtl/ir_defs.sv
// Shared NEC IR definitions: state encodings, unit counts and default timing.
// IR_TX_REPEAT_EN adds the repeat-frame states.
package ir_defs;

  localparam int DEF_UNIT_CYC     = 28125;
  localparam int DEF_CARRIER_HALF = 658;
  localparam int DEF_GAP_U        = 72;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int ONE_SPACE_U  = 3;
  localparam int ZERO_SPACE_U = 1;
  localparam int REP_SPACE_U  = 4;
  localparam int REP_GAP_U    = 171;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LEAD_MARK  = 4'd1,
    ST_LEAD_SPACE = 4'd2,
    ST_BIT_MARK   = 4'd3,
    ST_BIT_SPACE  = 4'd4,
    ST_STOP_MARK  = 4'd5,
    ST_GAP        = 4'd6
`ifdef IR_TX_REPEAT_EN
    ,
    ST_REP_MARK   = 4'd7,
    ST_REP_SPACE  = 4'd8,
    ST_REP_STOP   = 4'd9,
    ST_REP_GAP    = 4'd10
`endif
  } ir_state_e;

  function automatic logic is_mark(ir_state_e s);
    case (s)
      ST_LEAD_MARK, ST_BIT_MARK, ST_STOP_MARK: return 1'b1;
`ifdef IR_TX_REPEAT_EN
      ST_REP_MARK, ST_REP_STOP: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Length of each state in NEC units; bit spaces depend on the bit being sent.
  function automatic logic [15:0] state_units(ir_state_e s, logic bit_val, logic [15:0] gap_u);
    case (s)
      ST_LEAD_MARK:  return 16'(LEAD_MARK_U);
      ST_LEAD_SPACE: return 16'(LEAD_SPACE_U);
      ST_BIT_SPACE:  return bit_val ? 16'(ONE_SPACE_U) : 16'(ZERO_SPACE_U);
      ST_GAP:        return gap_u;
`ifdef IR_TX_REPEAT_EN
      ST_REP_MARK:   return 16'(LEAD_MARK_U);
      ST_REP_SPACE:  return 16'(REP_SPACE_U);
      ST_REP_GAP:    return 16'(REP_GAP_U);
`endif
      default:       return 16'd1;
    endcase
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// 50 % duty carrier divider; restart forces the phase back to the start of the high half.
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 658
) (
  input  logic clk,
  input  logic res,
  input  logic restart,
  output logic carrier
);
  localparam int W = $clog2(2 * CARRIER_HALF);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge res) begin
    if (res)                                      cnt <= '0;
    else if (restart || cnt == W'(2 * CARRIER_HALF - 1)) cnt <= '0;
    else                                          cnt <= cnt + W'(1);
  end

  assign carrier = (cnt < W'(CARRIER_HALF));

endmodule

// File: rtl/nec_ir_transmitter.sv
// NEC IR transmitter: leader, 32 LSB-first data bits, stop mark, idle gap.
// Define IR_TX_REPEAT_EN to emit NEC repeat frames while start stays high.
module nec_ir_transmitter import ir_defs::*; #(
  parameter int UNIT_CYC     = DEF_UNIT_CYC,
  parameter int CARRIER_HALF = DEF_CARRIER_HALF,
  parameter int GAP_U        = DEF_GAP_U
) (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic [31:0] code,
  output logic        busy,
  output logic        done,
  output logic        ir_out
);
  localparam int TW = $clog2(UNIT_CYC + 1);

  ir_state_e     state, state_nxt;
  logic [TW-1:0] unit_tmr;
  logic [15:0]   unit_cnt, dur;
  logic [31:0]   shreg;
  logic [5:0]    bit_cnt;
  logic          unit_tick, last_unit, state_chg, frame_end, carrier;

  assign unit_tick = (unit_tmr == TW'(UNIT_CYC - 1));
  assign dur       = state_units(state, shreg[0], 16'(GAP_U));
  assign last_unit = unit_tick && (unit_cnt == dur - 16'd1);
  assign state_chg = (state_nxt != state);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      ST_IDLE:       if (start) state_nxt = ST_LEAD_MARK;
      ST_LEAD_MARK:  if (last_unit) state_nxt = ST_LEAD_SPACE;
      ST_LEAD_SPACE: if (last_unit) state_nxt = ST_BIT_MARK;
      ST_BIT_MARK:   if (last_unit) state_nxt = ST_BIT_SPACE;
      ST_BIT_SPACE:  if (last_unit) state_nxt = (bit_cnt == 6'd31) ? ST_STOP_MARK : ST_BIT_MARK;
      ST_STOP_MARK:  if (last_unit) state_nxt = ST_GAP;
      ST_GAP: if (last_unit) begin
        frame_end = 1'b1;
`ifdef IR_TX_REPEAT_EN
        state_nxt = start ? ST_REP_MARK : ST_IDLE;
`else
        state_nxt = ST_IDLE;
`endif
      end
`ifdef IR_TX_REPEAT_EN
      ST_REP_MARK:   if (last_unit) state_nxt = ST_REP_SPACE;
      ST_REP_SPACE:  if (last_unit) state_nxt = ST_REP_STOP;
      ST_REP_STOP:   if (last_unit) state_nxt = ST_REP_GAP;
      ST_REP_GAP: if (last_unit) begin
        frame_end = 1'b1;
        state_nxt = start ? ST_REP_MARK : ST_IDLE;
      end
`endif
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state    <= ST_IDLE;
      unit_tmr <= '0;
      unit_cnt <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      done     <= 1'b0;
      ir_out   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done   <= frame_end;
      ir_out <= is_mark(state) & carrier;
      // Timer restarts on every state change so unit boundaries never drift.
      if (state_chg || unit_tick) unit_tmr <= '0;
      else                        unit_tmr <= unit_tmr + TW'(1);
      if (state_chg)      unit_cnt <= '0;
      else if (unit_tick) unit_cnt <= unit_cnt + 16'd1;
      if (state == ST_IDLE && start) begin
        shreg   <= code;
        bit_cnt <= '0;
      end else if (state == ST_BIT_SPACE && last_unit) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

  ir_carrier_gen #(.CARRIER_HALF(CARRIER_HALF)) u_carrier (
    .clk     (clk),
    .res     (res),
    .restart (state_chg && is_mark(state_nxt)),
    .carrier (carrier)
  );

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Randomized bench for nec_ir_transmitter against a waveform model built from NEC segment rules.
module tb_nec_ir_transmitter;
  localparam int UNIT = 10;
  localparam int HALF = 2;
  localparam int GAP  = 72;
  localparam int CAP  = 2400;

  logic        clk, res, start, busy, done, ir_out;
  logic [31:0] code;

  int n_chk = 0;
  int n_err = 0;

  logic wq[$], dq[$], bq[$];
  logic exp_w[$];
  int   flen;

  nec_ir_transmitter #(.UNIT_CYC(UNIT), .CARRIER_HALF(HALF), .GAP_U(GAP)) dut (
    .clk(clk), .res(res), .start(start), .code(code),
    .busy(busy), .done(done), .ir_out(ir_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Model: a mark carries a fresh 1100.. carrier, a space is flat zero.
  task automatic seg(input bit mark, input int units);
    for (int i = 0; i < units * UNIT; i++)
      exp_w.push_back(mark && ((i % (2 * HALF)) < HALF));
  endtask

  task automatic model_frame(input logic [31:0] c);
    exp_w.delete();
    seg(1, 16); seg(0, 8);
    for (int b = 0; b < 32; b++) begin
      seg(1, 1); seg(0, c[b] ? 3 : 1);
    end
    seg(1, 1);
    flen = exp_w.size();
    seg(0, GAP);
  endtask

  task automatic send(input logic [31:0] c, input bit hold);
    @(negedge clk);
    code  = c;
    start = 1'b1;
    @(posedge clk); #1;
    chk("accept_busy", busy, 1'b1);
    if (!hold) start = 1'b0;
  endtask

  task automatic cap(input int n, input int inj);
    wq.delete(); dq.delete(); bq.delete();
    for (int k = 0; k < n; k++) begin
      if (inj >= 0 && k == inj) begin
        start = 1'b1; code = 32'h12345678;
      end else if (inj >= 0 && k == inj + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      wq.push_back(ir_out); dq.push_back(done); bq.push_back(busy);
    end
  endtask

  // Recover the payload from space widths: short zero runs are carrier troughs,
  // the first long run is the leader space, then one run per data bit.
  function automatic logic [31:0] decode(int upto);
    int run = 0;
    int nsp = 0;
    logic [31:0] r = '0;
    for (int k = 0; k < upto && k < wq.size(); k++) begin
      if (wq[k] == 1'b0) run++;
      else begin
        if (run >= 5) begin
          if (nsp >= 1 && nsp <= 32) r[nsp-1] = (run >= 20);
          nsp++;
        end
        run = 0;
      end
    end
    return r;
  endfunction

  task automatic frame_chk(input string p, input logic [31:0] c);
    int mis = 0;
    int nd  = 0;
    int len;
    model_frame(c);
    len = exp_w.size();
    for (int k = 0; k < len; k++) if (wq[k] !== exp_w[k]) mis++;
    for (int k = 0; k < wq.size(); k++) nd += int'(dq[k]);
    chk({p, "_wave"}, mis, 0);
    chk({p, "_decode"}, decode(flen), c);
    chk({p, "_done_at"}, dq[len-1], 1'b1);
    chk({p, "_ndone"}, nd, 1);
    chk({p, "_busy_last"}, bq[len-2], 1'b1);
    chk({p, "_busy_end"}, bq[len-1], 1'b0);
  endtask

  initial begin
    logic [31:0] c;
    int mis, len, nd;
    clk = 0; res = 1; start = 0; code = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ir", ir_out, 1'b0);
    @(negedge clk) res = 0;

    // Carrier shape on the leader of an all-zero frame.
    send(32'h0, 0);
    cap(CAP, -1);
    model_frame(32'h0);
    mis = 0;
    for (int k = 0; k < 240; k++) if (wq[k] !== exp_w[k]) mis++;
    chk("lead_shape", mis, 0);
    frame_chk("zero", 32'h0);

    send(32'h00FF00FF, 0);
    cap(CAP, -1);
    frame_chk("ff", 32'h00FF00FF);
    chk("ff_len", flen, 1210);

    // A start during the frame must not disturb the payload or add a done.
    send(32'h00FF00FF, 0);
    cap(CAP, 300);
    frame_chk("ignore", 32'h00FF00FF);

    for (int i = 0; i < 3; i++) begin
      c = $urandom;
      send(c, 0);
      cap(CAP, -1);
      frame_chk("rnd", c);
    end

    // Abort during the first data bit space.
    send($urandom | 32'h1, 0);
    cap(260, -1);
    res = 1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ir", ir_out, 1'b0);
    chk("midrst_done", done, 1'b0);
    @(negedge clk) res = 0;
    c = $urandom;
    send(c, 0);
    cap(CAP, -1);
    frame_chk("postrst", c);

`ifndef IR_TX_REPEAT_EN
    // Start held across the gap exit: one IDLE cycle, then a new frame.
    c = $urandom;
    model_frame(c);
    len = exp_w.size();
    send(c, 1);
    cap(len + 3, -1);
    chk("b2b_done", dq[len-1], 1'b1);
    chk("b2b_idle", bq[len-1], 1'b0);
    chk("b2b_rebusy", bq[len], 1'b1);
    chk("b2b_carrier", wq[len+1], 1'b1);
    start = 0;
    cap(len + 5, -1);
    nd = 0;
    for (int k = 0; k < wq.size(); k++) nd += int'(dq[k]);
    chk("b2b_ndone", nd, 1);
    chk("b2b_end_busy", bq[wq.size()-1], 1'b0);
`else
    // Held start: repeat frames every 192 units until start drops.
    c = $urandom;
    model_frame(c);
    len = exp_w.size();
    send(c, 1);
    cap(len, -1);
    chk("rep_first_done", dq[len-1], 1'b1);
    chk("rep_first_busy", bq[len-1], 1'b1);
    exp_w.delete();
    seg(1, 16); seg(0, 4); seg(1, 1); seg(0, 171);
    cap(1920, -1);
    mis = 0;
    for (int k = 0; k < 1920; k++) if (wq[k] !== exp_w[k]) mis++;
    chk("rep_wave", mis, 0);
    chk("rep_done", dq[1919], 1'b1);
    chk("rep_busy", bq[1919], 1'b1);
    start = 0;
    cap(1930, -1);
    nd = 0;
    for (int k = 0; k < wq.size(); k++) nd += int'(dq[k]);
    chk("rep_last_done", dq[1919], 1'b1);
    chk("rep_last_idle", bq[1919], 1'b0);
    chk("rep_ndone", nd, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
